// File: rtl/mano_pkg.sv
// Shared types for the memory-port initiator: widths, request opcodes, FSM states.
package mano_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      OP_READ    = 2'b00,
      OP_WRITE   = 2'b01,
      OP_RMW_INC = 2'b10,
      OP_RSVD    = 2'b11
   } mem_op_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_CAP   = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_RMW_WR   = 3'd4
   } mem_master_state_t;

endpackage

// File: rtl/mem_master.sv
// Initiator for the 4K x 16 synchronous memory: READ, WRITE and increment-RMW requests.
// Define MEM_MASTER_RMW_EN to build the RMW_INC path; otherwise op 10 reports err.
module mem_master #(
   parameter int ADDR_W = mano_pkg::ADDR_W,
   parameter int DATA_W = mano_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              zero,
   output logic              err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import mano_pkg::*;

   mem_master_state_t state_reg, state_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   logic              mem_read_reg, mem_read_next;
   logic              mem_write_reg, mem_write_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic [DATA_W-1:0] rdata_reg, rdata_next;
   logic              zero_reg;
   logic              rmw_reg;
   logic [DATA_W-1:0] inc_value;
   mem_op_t           op_in;

   assign op_in = mem_op_t'(op);
   assign ready = (state_reg == ST_IDLE);

`ifdef MEM_MASTER_RMW_EN
   assign inc_value = DATA_W'(mem_rdata + 1'b1);

   // rmw_reg steers RD_CAP into the write-back leg; zero follows every done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rmw_reg  <= 1'b0;
         zero_reg <= 1'b0;
      end else begin
         if (ready && req)
            rmw_reg <= (op_in == OP_RMW_INC);
         if (done_next)
            zero_reg <= (state_reg == ST_RMW_WR) && (mem_wdata_reg == '0);
      end
   end
`else
   assign inc_value = '0;
   assign rmw_reg   = 1'b0;
   assign zero_reg  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         rdata_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
         mem_read_reg  <= mem_read_next;
         mem_write_reg <= mem_write_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         rdata_reg     <= rdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               case (op_in)
                  OP_READ:    state_next = ST_RD_ISSUE;
                  OP_WRITE:   state_next = ST_WR_ISSUE;
`ifdef MEM_MASTER_RMW_EN
                  OP_RMW_INC: state_next = ST_RD_ISSUE;
`endif
                  default:    state_next = ST_IDLE;
               endcase
            end
         end
         ST_RD_ISSUE: state_next = ST_RD_CAP;
         ST_RD_CAP:   state_next = rmw_reg ? ST_RMW_WR : ST_IDLE;
         ST_WR_ISSUE: state_next = ST_IDLE;
         ST_RMW_WR:   state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; mem_addr only moves on an accepted access.
   always_comb begin
      done_next      = 1'b0;
      err_next       = 1'b0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      rdata_next     = rdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               case (op_in)
                  OP_READ: begin
                     mem_read_next = 1'b1;
                     mem_addr_next = addr;
                  end
                  OP_WRITE: begin
                     mem_write_next = 1'b1;
                     mem_addr_next  = addr;
                     mem_wdata_next = wdata;
                  end
`ifdef MEM_MASTER_RMW_EN
                  OP_RMW_INC: begin
                     mem_read_next = 1'b1;
                     mem_addr_next = addr;
                  end
`endif
                  default: begin
                     done_next = 1'b1;
                     err_next  = 1'b1;
                  end
               endcase
            end
         end
         ST_RD_CAP: begin
            if (rmw_reg) begin
               mem_write_next = 1'b1;
               mem_wdata_next = inc_value;
            end else begin
               rdata_next = mem_rdata;
               done_next  = 1'b1;
            end
         end
         ST_WR_ISSUE: done_next = 1'b1;
         ST_RMW_WR: begin
            rdata_next = mem_wdata_reg;
            done_next  = 1'b1;
         end
         default: ;
      endcase
   end

   assign done      = done_reg;
   assign err       = err_reg;
   assign zero      = zero_reg;
   assign rdata     = rdata_reg;
   assign mem_read  = mem_read_reg;
   assign mem_write = mem_write_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule
